// File: rtl/count_monitor.sv
// count_monitor: checks a wrapping MAX_COUNT->0 counter stream, locks after LOCK_LEN good samples, pulses on errors; outputs registered, 1 clk latency, no backpressure.
// Define COUNT_MONITOR_ERR_CNT_EN to build the saturating err_count register; otherwise err_count is tied to 0.
module count_monitor #(
  parameter int MAX_COUNT = 5,
  parameter int LOCK_LEN  = 3,
  localparam int W = $clog2(MAX_COUNT) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_count,
  input  logic         clear,
  output logic         locked,
  output logic         err_pulse,
  output logic [W-1:0] expected,
  output logic [15:0]  err_count
);

  localparam logic [W-1:0] MAX_V  = W'(MAX_COUNT);
  localparam logic [3:0]   LOCK_V = 4'(LOCK_LEN);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t     state;
  logic [3:0] match_cnt;
  logic       hit;
  logic       oor;

  // expected is always in range, so a hit can never be an out-of-range sample
  assign hit = (in_count == expected);
  assign oor = (in_count > MAX_V);

  function automatic logic [W-1:0] succ(input logic [W-1:0] v);
    succ = (v == MAX_V) ? '0 : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      expected  <= '0;
    end else if (clear) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      expected  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          UNLOCKED: begin
            if (!oor) begin
              expected  <= succ(in_count);
              match_cnt <= 4'd1;
              if (LOCK_LEN == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state <= ACQUIRE;
              end
            end
          end
          ACQUIRE: begin
            if (hit) begin
              expected  <= succ(in_count);
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt + 4'd1 == LOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (!oor) begin
              // a broken run restarts from the new sample
              expected  <= succ(in_count);
              match_cnt <= 4'd1;
            end else begin
              state     <= UNLOCKED;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= succ(in_count);
            end else begin
              state     <= UNLOCKED;
              match_cnt <= '0;
              locked    <= 1'b0;
              err_pulse <= 1'b1;
            end
          end
          default: begin
            state     <= UNLOCKED;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef COUNT_MONITOR_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (clear) begin
      err_cnt_q <= '0;
    end else if (in_valid && state == LOCKED && !hit && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor (MAX_COUNT=5, LOCK_LEN=3): directed table, reset corner case, randomized run vs. model.
module tb_count_monitor;

  localparam int MAXC = 5;
  localparam int LLEN = 3;
  localparam int W    = 4;

  logic         tb_clk;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_count;
  logic         clear;
  logic         locked;
  logic         err_pulse;
  logic [W-1:0] expected;
  logic [15:0]  err_count;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: run length of consecutive good successors plus lock flag
  bit m_locked;
  int m_run;
  int m_exp;
  int m_errs;
  bit m_pulse;

  count_monitor #(.MAX_COUNT(MAXC), .LOCK_LEN(LLEN)) dut (
    .clk       (tb_clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .expected  (expected),
    .err_count (err_count)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  function automatic int ec(input int v);
`ifdef COUNT_MONITOR_ERR_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_run = 0; m_exp = 0; m_errs = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(input bit v, input int c, input bit clr);
    m_pulse = 0;
    if (clr) begin
      model_reset();
    end else if (v) begin
      if (m_locked) begin
        if (c == m_exp) m_exp = (c + 1) % (MAXC + 1);
        else begin
          m_pulse  = 1;
          m_errs   = (m_errs < 65535) ? m_errs + 1 : 65535;
          m_locked = 0;
          m_run    = 0;
        end
      end else if (m_run > 0 && c == m_exp) begin
        m_run++;
        m_exp = (c + 1) % (MAXC + 1);
        if (m_run >= LLEN) m_locked = 1;
      end else if (c <= MAXC) begin
        m_run    = 1;
        m_exp    = (c + 1) % (MAXC + 1);
        m_locked = (LLEN == 1);
      end else begin
        m_run = 0;
      end
    end
  endfunction

  task automatic check(input string name, input bit el, input bit ep, input int ee, input int ecn);
    n_vec++;
    if (locked !== el || err_pulse !== ep || int'(expected) != ee || int'(err_count) != ecn) begin
      n_bad++;
      $display("FAIL %s: got locked=%0d err_pulse=%0d expected=%0d err_count=%0d, want locked=%0d err_pulse=%0d expected=%0d err_count=%0d",
               name, locked, err_pulse, expected, err_count, el, ep, ee, ecn);
    end
  endtask

  // inputs change 1 time unit after the edge; outputs read 1 unit after the sampling edge
  task automatic apply(input bit v, input int c, input bit clr);
    in_valid = v;
    in_count = W'(c);
    clear    = clr;
    @(posedge tb_clk);
    model_step(v, c, clr);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  typedef struct {
    bit    v;
    int    c;
    bit    clr;
    bit    el;
    bit    ep;
    int    ee;
    int    ecn;
    string name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1, 2, 0, 0, 0, 3, 0, "seed_2"},
      '{1, 3, 0, 0, 0, 4, 0, "acq_3"},
      '{1, 4, 0, 1, 0, 5, 0, "lock_on_4"},
      '{1, 5, 0, 1, 0, 0, 0, "locked_5"},
      '{1, 0, 0, 1, 0, 1, 0, "wrap_0"},
      '{1, 1, 0, 1, 0, 2, 0, "locked_1"},
      '{0, 9, 0, 1, 0, 2, 0, "idle_hold"},
      '{1, 3, 0, 0, 1, 2, 1, "skip_err"},
      '{1, 4, 0, 0, 0, 5, 1, "reseed_4"},
      '{1, 5, 0, 0, 0, 0, 1, "acq_5"},
      '{1, 0, 0, 1, 0, 1, 1, "relock_0"},
      '{1, 7, 0, 0, 1, 1, 2, "oor_locked"},
      '{1, 7, 0, 0, 0, 1, 2, "oor_unlocked"},
      '{1, 2, 0, 0, 0, 3, 2, "seed_2b"},
      '{1, 3, 0, 0, 0, 4, 2, "acq_3b"},
      '{1, 3, 0, 0, 0, 4, 2, "repeat_reseed"},
      '{1, 4, 0, 0, 0, 5, 2, "acq_4b"},
      '{1, 0, 0, 0, 0, 1, 2, "skip_reseed"},
      '{1, 1, 0, 0, 0, 2, 2, "acq_1"},
      '{1, 2, 0, 1, 0, 3, 2, "lock_2"},
      '{1, 3, 1, 0, 0, 0, 0, "clear_wins"},
      '{1, 9, 0, 0, 0, 0, 0, "oor_after_clear"}
    };

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_count = '0;
    clear    = 1'b0;
    model_reset();
    repeat (2) @(posedge tb_clk);
    #1;
    check("reset_state", 0, 0, 0, 0);
    #2 reset_n = 1'b1;
    #2;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].c, tbl[i].clr);
      check(tbl[i].name, tbl[i].el, tbl[i].ep, tbl[i].ee, ec(tbl[i].ecn));
    end

    // build up an error and a partial acquisition, then reset asynchronously
    apply(1, 3, 0); apply(1, 4, 0); apply(1, 5, 0);
    check("relock_pre_rst", 1, 0, 0, 0);
    apply(1, 1, 0);
    check("err_pre_rst", 0, 1, 0, ec(1));
    apply(1, 2, 0); apply(1, 3, 0);
    check("acq_pre_rst", 0, 0, 4, ec(1));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0);
    model_reset();
    #1 reset_n = 1'b1;
    @(posedge tb_clk); #1;
    apply(1, 3, 0);
    check("first_edge_after_rst", 0, 0, 4, 0);
    apply(1, 4, 0); apply(1, 5, 0);
    check("lock_after_rst", 1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit clr;
      int c;
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 99) < 2);
      c   = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 15));
      apply(v, c, clr);
      check("random", m_locked, m_pulse, m_exp, ec(m_errs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
